// File: rtl/acquire_mcb_arbiter_pkg.sv
// Shared encodings for the acquisition MCB arbiter: FSM states, grant codes
// and the write-vs-read arbitration decision.
package acquire_mcb_arbiter_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_RWAIT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic GNT_WR = 1'b1;
  localparam logic GNT_RD = 1'b0;

  // Writes win when the buffer is nearly full, when no read competes, or
  // when the previous grant went to the read side.
  function automatic logic pick_write(input logic wr_el, input logic rd_el,
                                      input logic high, input logic last);
    return wr_el & (high | ~rd_el | (last == GNT_RD));
  endfunction

endpackage

// File: rtl/acquire_mcb_arbiter_if.sv
// Command/data bundle between the arbiter (master) and the SDRAM MCB (slave).
interface acquire_mcb_arbiter_if #(
  parameter int ABITS = 20
);
  import acquire_mcb_arbiter_pkg::*;

  logic              ce;
  logic              wr;
  logic              rdy;
  logic [ABITS-1:0]  adr;
  logic [DATA_W-1:0] dat_w;
  logic [DATA_W-1:0] dat_r;
  logic              ack;

  modport master (output ce, wr, adr, dat_w, input rdy, dat_r, ack);
  modport slave  (input ce, wr, adr, dat_w, output rdy, dat_r, ack);

endinterface

// File: rtl/acquire_addr_gen.sv
// SDRAM write/read word pointers with end-of-memory and empty detection.
module acquire_addr_gen #(
  parameter int ABITS = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_inc_i,
  input  logic             rd_inc_i,
  output logic [ABITS-1:0] wr_ptr_o,
  output logic [ABITS-1:0] rd_ptr_o,
  output logic             wr_last_o,
  output logic             ptr_eq_o
);

  logic [ABITS-1:0] wr_ptr_q;
  logic [ABITS-1:0] rd_ptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_inc_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_inc_i) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign wr_ptr_o  = wr_ptr_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign wr_last_o = &wr_ptr_q;
  assign ptr_eq_o  = (wr_ptr_q == rd_ptr_q);

endmodule

// File: rtl/acquire_mcb_arbiter.sv
// Shares the SDRAM MCB between the capture drain (writes) and host readback
// (reads); flags capture completion and block-buffer overflow.
module acquire_mcb_arbiter
  import acquire_mcb_arbiter_pkg::*;
#(
  parameter int ABITS = 20,
  parameter int FBITS = 9,
  parameter int HIGH  = 384
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic [FBITS:0]        level_i,
  input  logic [DATA_W-1:0]     wr_dat_i,
  output logic                  wr_ack_o,
  input  logic                  rd_req_i,
  output logic                  rd_ack_o,
  output logic [DATA_W-1:0]     rd_dat_o,
  acquire_mcb_arbiter_if.master mcb,
  output logic                  done_o,
  output logic                  oflow_o,
  output logic [2:0]            state_o
);

  localparam logic [FBITS:0] LVL_HIGH = (FBITS+1)'(HIGH);
  localparam logic [FBITS:0] LVL_FULL = {1'b1, {FBITS{1'b0}}};

  state_t            state_q;
  logic              ce_q, wr_q, rd_ack_q, done_q, oflow_q, last_q;
  logic [ABITS-1:0]  adr_q;
  logic [DATA_W-1:0] dat_q, rd_dat_q;

  logic [ABITS-1:0]  wr_ptr, rd_ptr;
  logic              wr_last, ptr_eq;
  logic              wr_acc, rd_done, wr_el, rd_el, go_wr, go_rd;

  // The pop strobe coincides with the acceptance cycle so the buffer level
  // is already updated when the FSM re-arbitrates in IDLE.
  assign wr_acc  = (state_q == ST_WRITE) & mcb.rdy & ~reset_i;
  assign rd_done = (state_q == ST_RWAIT) & mcb.ack & ~reset_i;

  acquire_addr_gen #(.ABITS(ABITS)) u_addr_gen (
    .clk_i     (clock_i),
    .rst_i     (reset_i),
    .wr_inc_i  (wr_acc),
    .rd_inc_i  (rd_done),
    .wr_ptr_o  (wr_ptr),
    .rd_ptr_o  (rd_ptr),
    .wr_last_o (wr_last),
    .ptr_eq_o  (ptr_eq)
  );

  // A request is treated as consumed during its own ack cycle, since the host
  // only sees the strobe at the end of it.
  assign wr_el = enable_i & (level_i != '0) & ~done_q;
  assign rd_el = rd_req_i & ~rd_ack_q & (done_q | ~ptr_eq);
  assign go_wr = pick_write(wr_el, rd_el, level_i >= LVL_HIGH, last_q);
  assign go_rd = rd_el & ~go_wr;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      ce_q     <= 1'b0;
      wr_q     <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      rd_ack_q <= 1'b0;
      rd_dat_q <= '0;
      done_q   <= 1'b0;
      oflow_q  <= 1'b0;
      last_q   <= GNT_RD;
    end else begin
      rd_ack_q <= 1'b0;
      if (enable_i && level_i == LVL_FULL) oflow_q <= 1'b1;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (go_wr) begin
            state_q <= ST_WRITE;
            ce_q    <= 1'b1;
            wr_q    <= 1'b1;
            adr_q   <= wr_ptr;
            dat_q   <= wr_dat_i;
            last_q  <= GNT_WR;
          end else if (go_rd) begin
            state_q <= ST_READ;
            ce_q    <= 1'b1;
            wr_q    <= 1'b0;
            adr_q   <= rd_ptr;
            last_q  <= GNT_RD;
          end
        end
        ST_WRITE: begin
          if (mcb.rdy) begin
            ce_q <= 1'b0;
            wr_q <= 1'b0;
            if (wr_last) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_READ: begin
          if (mcb.rdy) begin
            ce_q    <= 1'b0;
            state_q <= ST_RWAIT;
          end
        end
        ST_RWAIT: begin
          if (mcb.ack) begin
            rd_dat_q <= mcb.dat_r;
            rd_ack_q <= 1'b1;
            state_q  <= done_q ? ST_DONE : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wr_ack_o  = wr_acc;
  assign rd_ack_o  = rd_ack_q;
  assign rd_dat_o  = rd_dat_q;
  assign mcb.ce    = ce_q;
  assign mcb.wr    = wr_q;
  assign mcb.adr   = adr_q;
  assign mcb.dat_w = dat_q;
  assign done_o    = done_q;
  assign oflow_o   = oflow_q;
  assign state_o   = state_q;

endmodule
